// File: rtl/dp_pkg.sv
// Shared types and constants for the dp register-transfer datapath.
package dp_pkg;

    localparam int unsigned DP_WIDTH = 8;

    typedef logic [DP_WIDTH-1:0] data_t;

    // Control strobes that the control unit will drive into the datapath.
    typedef struct packed {
        logic rz_out;
        logic ra_out;
        logic rb_out;
        logic ra_in;
        logic rb_in;
        logic rz_in;
    } ctrl_t;

endpackage

// File: rtl/dp_adder.sv
// Ripple-carry adder built from a generate-chained full-adder cell.

// Single-bit full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    // Sum and carry of one bit position.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end
endmodule

// WIDTH-bit ripple-carry adder.
module rc_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    // Carry ripples from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end
endmodule

// File: rtl/dp.sv
// Execution datapath: registers A, B, Z on one shared bus plus an immediate adder.
module dp
    import dp_pkg::*;
#(
    parameter int unsigned WIDTH = DP_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] AddImmediate,
    input  logic [WIDTH-1:0] RegisterAImmediate,
    input  logic             RZout,
    input  logic             RAout,
    input  logic             RBout,
    input  logic             RAin,
    input  logic             RBin,
    input  logic             RZin,
    output logic [WIDTH-1:0] RA_q,
    output logic [WIDTH-1:0] RB_q,
    output logic [WIDTH-1:0] RZ_q,
    output logic [WIDTH-1:0] BusOut
);

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] sum;
    logic             carry_unused;

    // Bus source select; Z wins over A wins over B, immediate when idle.
    always_comb begin
        bus = RegisterAImmediate;
        if (RZout) begin
            bus = RZ_q;
        end else if (RAout) begin
            bus = RA_q;
        end else if (RBout) begin
            bus = RB_q;
        end
    end

    assign BusOut = bus;

    // Carry-out is dropped so the sum wraps.
    rc_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (bus),
        .b    (AddImmediate),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry_unused)
    );

    // Register file: each register loads on its strobe, clear wins asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            RA_q <= '0;
            RB_q <= '0;
            RZ_q <= '0;
        end else begin
            if (RAin) RA_q <= bus;
            if (RBin) RB_q <= bus;
            if (RZin) RZ_q <= sum;
        end
    end

endmodule

// File: tb/tb_dp.sv
// Self-checking bench for dp: a reference model pushes expected register
// states to a scoreboard, popped and compared after each rising edge.
module tb_dp;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear;
    logic [W-1:0] AddImmediate;
    logic [W-1:0] RegisterAImmediate;
    logic         RZout, RAout, RBout, RAin, RBin, RZin;
    logic [W-1:0] RA_q, RB_q, RZ_q, BusOut;

    int tests = 0;
    int fails = 0;

    exp_t         sb[$];
    logic [W-1:0] m_a = '0, m_b = '0, m_z = '0;

    dp #(.WIDTH(W)) dut (
        .clock              (clock),
        .clear              (clear),
        .AddImmediate       (AddImmediate),
        .RegisterAImmediate (RegisterAImmediate),
        .RZout              (RZout),
        .RAout              (RAout),
        .RBout              (RBout),
        .RAin               (RAin),
        .RBin               (RBin),
        .RZin               (RZin),
        .RA_q               (RA_q),
        .RB_q               (RB_q),
        .RZ_q               (RZ_q),
        .BusOut             (BusOut)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // One instruction cycle: drive on the falling edge, model, compare after rising edge.
    task automatic step(input logic zo, input logic ao, input logic bo,
                        input logic ai, input logic bi, input logic zi,
                        input logic [W-1:0] rimm, input logic [W-1:0] aimm);
        logic [W-1:0] bus_m;
        logic [W-1:0] sum_m;
        exp_t e;
        @(negedge clock);
        RZout = zo; RAout = ao; RBout = bo;
        RAin = ai; RBin = bi; RZin = zi;
        RegisterAImmediate = rimm;
        AddImmediate = aimm;
        bus_m = zo ? m_z : (ao ? m_a : (bo ? m_b : rimm));
        sum_m = W'(bus_m + aimm);
        if (ai) m_a = bus_m;
        if (bi) m_b = bus_m;
        if (zi) m_z = sum_m;
        e.a = m_a; e.b = m_b; e.z = m_z;
        sb.push_back(e);
        #1;
        check("bus", BusOut, bus_m);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            check("ra", RA_q, e.a);
            check("rb", RB_q, e.b);
            check("rz", RZ_q, e.z);
        end
    endtask

    initial begin
        clear = 1'b1;
        {RZout, RAout, RBout, RAin, RBin, RZin} = '0;
        AddImmediate = '0;
        RegisterAImmediate = 8'h33;
        #1;
        check("rst_ra", RA_q, 8'h00);
        check("rst_rb", RB_q, 8'h00);
        check("rst_rz", RZ_q, 8'h00);
        check("rst_bus", BusOut, 8'h33);
        @(negedge clock);
        clear = 1'b0;
        step(0, 0, 0, 0, 0, 0, 8'h33, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h44, 8'h11);

        // ldi A,5 ; addi Z,A,5 ; mv B,Z
        step(0, 0, 0, 1, 0, 0, 8'h05, 8'h00);
        check("ldi_a", RA_q, 8'h05);
        step(0, 1, 0, 0, 0, 1, 8'h00, 8'h05);
        check("addi_z", RZ_q, 8'h0A);
        step(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        check("mv_b", RB_q, 8'h0A);
        check("mv_a_hold", RA_q, 8'h05);
        check("mv_z_hold", RZ_q, 8'h0A);

        // Wrap-around
        step(0, 0, 0, 1, 0, 0, 8'hFF, 8'h00);
        step(0, 1, 0, 0, 0, 1, 8'h00, 8'h02);
        check("wrap_z", RZ_q, 8'h01);

        // Priority: Z beats A
        step(0, 0, 0, 1, 0, 0, 8'h03, 8'h00);
        step(0, 1, 0, 0, 0, 1, 8'h00, 8'h04);
        step(1, 1, 0, 0, 1, 0, 8'h00, 8'h00);
        check("prio_b", RB_q, 8'h07);

        // Self-load of A keeps it unchanged
        step(0, 1, 0, 1, 0, 0, 8'hEE, 8'h00);
        check("self_a", RA_q, 8'h03);

        // Clear overlapping the load edge aborts the load
        @(negedge clock);
        RAin = 1'b1;
        RegisterAImmediate = 8'h5A;
        #2;
        clear = 1'b1;
        m_a = '0; m_b = '0; m_z = '0;
        #1;
        check("clr_async_ra", RA_q, 8'h00);
        check("clr_async_rb", RB_q, 8'h00);
        check("clr_async_rz", RZ_q, 8'h00);
        @(posedge clock);
        #1;
        check("clr_edge_ra", RA_q, 8'h00);
        @(negedge clock);
        clear = 1'b0;
        RAin = 1'b0;
        step(0, 0, 0, 1, 0, 0, 8'h5A, 8'h00);
        check("reload_a", RA_q, 8'h5A);

        // Accumulate Z
        step(0, 0, 0, 0, 0, 1, 8'h04, 8'h00);
        step(1, 0, 0, 0, 0, 1, 8'h00, 8'h03);
        check("acc1", RZ_q, 8'h07);
        step(1, 0, 0, 0, 0, 1, 8'h00, 8'h03);
        check("acc2", RZ_q, 8'h0A);

        // Simultaneous loads from one bus value
        step(0, 0, 0, 1, 1, 1, 8'h20, 8'h01);
        check("sim_z", RZ_q, 8'h21);

        // Random strobe mix
        for (int i = 0; i < 24; i++) begin
            logic [2:0] outs;
            logic [2:0] ins;
            outs = 3'($urandom_range(0, 7));
            ins  = 3'($urandom_range(0, 7));
            step(outs[2], outs[1], outs[0], ins[2], ins[1], ins[0],
                 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
